xres_filter_mc: RTL and testbench

- Parametrised, clocked successor to the single-channel XRES pad receiver.
- Conditions NUM_CH external reset inputs: synchroniser, per-channel source select (PAD or FILT_IN_H), digital glitch filter and deassertion stretch.
- Also checks the power-mode enables and produces a combined reset.
- Sits between the XRES pad cells and the core reset tree.

---
 rtl/xres_filter_mc.sv | 167 ++++++++++++++++
 tb/tb_xres_filter_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xres_filter_mc.sv
// Multi-channel XRES receiver: source select, synchroniser, glitch filter and release stretch.
// Optional per-channel glitch counters are built when XRES_FILTER_MC_GLITCH_CNT_EN is defined.
module xres_filter_mc #(
  parameter int NUM_CH         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_CYCLES    = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       PAD,
  input  logic [NUM_CH-1:0]       FILT_IN_H,
  input  logic [NUM_CH-1:0]       INP_SEL_H,
  input  logic                    ENABLE_H,
  input  logic                    EN_VDDIO_SIG_H,
  input  logic                    ENABLE_VDDIO,
  input  logic                    CNT_CLR,
  output logic [NUM_CH-1:0]       XRES_H_N,
  output logic                    XRES_ALL_H_N,
  output logic [NUM_CH-1:0]       GLITCH,
  output logic                    MODE_ERR,
  output logic [NUM_CH*CNT_W-1:0] GLITCH_CNT
);

  typedef enum logic [2:0] {HI, LOW_Q, LO, RISE_Q, STRETCH} state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'(STRETCH_CYCLES - 1);

  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;
  logic              mode_vcchib;

  assign src         = (INP_SEL_H & FILT_IN_H) | (~INP_SEL_H & PAD);
  assign s           = sync_q[SYNC_STAGES-1];
  assign mode_vcchib = ENABLE_H & ~EN_VDDIO_SIG_H;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      MODE_ERR     <= 1'b0;
      XRES_ALL_H_N <= 1'b0;
    end else begin
      sync_q[0] <= src;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      MODE_ERR     <= mode_vcchib & ~ENABLE_VDDIO;
      XRES_ALL_H_N <= &XRES_H_N;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             xres_q;
    logic             glitch_q;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        state    <= RISE_Q;
        cnt      <= '0;
        xres_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else if (MODE_ERR) begin
        glitch_q <= 1'b0;
      end else begin
        glitch_q <= 1'b0;
        unique case (state)
          HI: if (!s[i]) begin
            if (FILT_CYCLES == 1) begin
              state  <= LO;
              cnt    <= '0;
              xres_q <= 1'b0;
            end else begin
              state <= LOW_Q;
              cnt   <= ONE;
            end
          end
          LOW_Q: begin
            if (s[i]) begin
              state    <= HI;
              cnt      <= '0;
              glitch_q <= 1'b1;
            end else if (cnt == FILT_LAST) begin
              state  <= LO;
              cnt    <= '0;
              xres_q <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          LO: if (s[i]) begin
            if (FILT_CYCLES != 1) begin
              state <= RISE_Q;
              cnt   <= ONE;
            end else if (STRETCH_CYCLES != 0) begin
              state <= STRETCH;
              cnt   <= '0;
            end else begin
              state  <= HI;
              cnt    <= '0;
              xres_q <= 1'b1;
            end
          end
          RISE_Q: begin
            // cnt == 0 only right after RESET: no attempt has started, so no GLITCH.
            if (!s[i]) begin
              state    <= LO;
              cnt      <= '0;
              glitch_q <= (cnt != '0);
            end else if (cnt == FILT_LAST) begin
              cnt <= '0;
              if (STRETCH_CYCLES != 0) begin
                state <= STRETCH;
              end else begin
                state  <= HI;
                xres_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STRETCH: begin
            if (!s[i]) begin
              state <= LO;
              cnt   <= '0;
            end else if (cnt == STR_LAST) begin
              state  <= HI;
              cnt    <= '0;
              xres_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state  <= LO;
            cnt    <= '0;
            xres_q <= 1'b0;
          end
        endcase
      end
    end

    assign XRES_H_N[i] = xres_q;
    assign GLITCH[i]   = glitch_q;

`ifdef XRES_FILTER_MC_GLITCH_CNT_EN
    logic [CNT_W-1:0] gcnt;

    always_ff @(posedge CLK) begin
      if (RESET || CNT_CLR) gcnt <= '0;
      else if (glitch_q && (gcnt != '1)) gcnt <= gcnt + ONE;
    end

    assign GLITCH_CNT[i*CNT_W +: CNT_W] = gcnt;
`endif
  end

`ifndef XRES_FILTER_MC_GLITCH_CNT_EN
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign GLITCH_CNT     = '0;
`endif

endmodule

// File: tb/tb_xres_filter_mc.sv
// Self-checking bench for xres_filter_mc (default parameters): directed test-plan steps,
// then randomized traffic, all compared each cycle against a behavioural reference model.
module tb_xres_filter_mc;
  localparam int NCH = 2, SS = 2, FILT = 4, STR = 8, CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    pad, filt_in, sel;
  logic          en_h, en_sig, en_vddio, cnt_clr;
  logic [1:0]    xres, glitch;
  logic          xres_all, merr;
  logic [15:0]   gcnt;

  int checks = 0;
  int failures = 0;

  xres_filter_mc #(.NUM_CH(NCH), .SYNC_STAGES(SS), .FILT_CYCLES(FILT),
                   .STRETCH_CYCLES(STR), .CNT_W(CW)) dut (
    .CLK(clk), .RESET(reset), .PAD(pad), .FILT_IN_H(filt_in), .INP_SEL_H(sel),
    .ENABLE_H(en_h), .EN_VDDIO_SIG_H(en_sig), .ENABLE_VDDIO(en_vddio), .CNT_CLR(cnt_clr),
    .XRES_H_N(xres), .XRES_ALL_H_N(xres_all), .GLITCH(glitch), .MODE_ERR(merr),
    .GLITCH_CNT(gcnt));

  always #5 clk = ~clk;

  // Reference model: released flag, count of accepted opposite samples, stretch cycles left.
  logic [1:0] m_rel, m_gl, m_all_v;
  logic       m_merr, m_all;
  logic [1:0] m_sync [SS];
  int         m_qual [2];
  int         m_str [2];
  int         m_gcnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void chan_step(input int ch, input logic s);
    if (m_rel[ch]) begin
      if (!s) begin
        m_qual[ch]++;
        if (m_qual[ch] == FILT) begin m_rel[ch] = 1'b0; m_qual[ch] = 0; end
      end else begin
        if (m_qual[ch] > 0) m_gl[ch] = 1'b1;
        m_qual[ch] = 0;
      end
    end else if (m_str[ch] > 0) begin
      if (!s) begin m_str[ch] = 0; m_qual[ch] = 0; end
      else begin
        m_str[ch]--;
        if (m_str[ch] == 0) m_rel[ch] = 1'b1;
      end
    end else begin
      if (s) begin
        m_qual[ch]++;
        if (m_qual[ch] == FILT) begin
          m_qual[ch] = 0;
          if (STR > 0) m_str[ch] = STR; else m_rel[ch] = 1'b1;
        end
      end else begin
        if (m_qual[ch] > 0) m_gl[ch] = 1'b1;
        m_qual[ch] = 0;
      end
    end
  endfunction

  function automatic void step_model();
    logic       frozen;
    logic [1:0] s, src;
    if (reset) begin
      m_rel = '0; m_gl = '0; m_merr = 1'b0; m_all = 1'b0;
      for (int k = 0; k < SS; k++) m_sync[k] = '0;
      for (int c = 0; c < 2; c++) begin m_qual[c] = 0; m_str[c] = 0; m_gcnt[c] = 0; end
    end else begin
      frozen = m_merr;
      s      = m_sync[SS-1];
      m_all  = &m_rel;
`ifdef XRES_FILTER_MC_GLITCH_CNT_EN
      for (int c = 0; c < 2; c++)
        if (cnt_clr) m_gcnt[c] = 0;
        else if (m_gl[c] && m_gcnt[c] < 255) m_gcnt[c]++;
`endif
      for (int c = 0; c < 2; c++) src[c] = sel[c] ? filt_in[c] : pad[c];
      for (int k = SS-1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = src;
      m_merr = en_h & ~en_sig & ~en_vddio;
      m_gl = '0;
      if (!frozen) for (int c = 0; c < 2; c++) chan_step(c, s[c]);
    end
  endfunction

  task automatic check_all();
    chk("xres_h_n", {30'd0, xres}, {30'd0, m_rel});
    chk("xres_all", {31'd0, xres_all}, {31'd0, m_all});
    chk("glitch", {30'd0, glitch}, {30'd0, m_gl});
    chk("mode_err", {31'd0, merr}, {31'd0, m_merr});
    chk("glitch_cnt", {16'd0, gcnt}, {16'd0, m_gcnt[1][7:0], m_gcnt[0][7:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
    check_all();
  endtask

  // Tick until xres[ch] == val (bounded) and compare the number of edges taken.
  task automatic wait_xres(input int ch, input logic val, input int exp_n, input string tag);
    int n = 0;
    do begin tick(); n++; end while (xres[ch] !== val && n < 60);
    chk(tag, n, exp_n);
  endtask

  int gl_pulses;
  int n;

  initial begin
    reset = 1'b1; pad = 2'b11; filt_in = 2'b11; sel = 2'b00;
    en_h = 1'b0; en_sig = 1'b0; en_vddio = 1'b1; cnt_clr = 1'b0;
    repeat (3) tick();
    chk("reset_xres", {30'd0, xres}, 32'd0);

    // Release from reset with both pads high.
    reset = 1'b0;
    wait_xres(0, 1'b1, 14, "release_latency");
    chk("release_both", {30'd0, xres}, 32'd3);
    chk("all_lags", {31'd0, xres_all}, 32'd0);
    tick();
    chk("all_high", {31'd0, xres_all}, 32'd1);

    // Three-cycle low pulse on PAD[0] is rejected.
    pad[0] = 1'b0; repeat (3) tick(); pad[0] = 1'b1;
    gl_pulses = 0;
    repeat (10) begin tick(); gl_pulses += int'(glitch[0]); end
    chk("glitch_once", gl_pulses, 32'd1);
    chk("glitch_xres_hold", {31'd0, xres[0]}, 32'd1);

    // Ten-cycle low on PAD[1].
    pad[1] = 1'b0;
    wait_xres(1, 1'b0, 6, "fall_latency");
    chk("ch0_unaffected", {31'd0, xres[0]}, 32'd1);
    repeat (4) tick();
    pad[1] = 1'b1;
    wait_xres(1, 1'b1, 14, "rise_latency");

    // Invalid power mode freezes filtering.
    en_h = 1'b1; en_sig = 1'b0; en_vddio = 1'b0;
    tick();
    chk("mode_err_set", {31'd0, merr}, 32'd1);
    pad = 2'b00;
    repeat (12) tick();
    chk("frozen_xres", {30'd0, xres}, 32'd3);
    en_vddio = 1'b1;
    tick();
    wait_xres(0, 1'b0, 4, "resume_fall");
    pad = 2'b11;
    wait_xres(0, 1'b1, 14, "resume_rise");
    tick();

    // Alternate input selected on channel 0.
    filt_in[0] = 1'b0; sel[0] = 1'b1;
    wait_xres(0, 1'b0, 6, "sel_fall");
    filt_in[0] = 1'b1;
    wait_xres(0, 1'b1, 14, "sel_rise");
    sel[0] = 1'b0;

    // New low during STRETCH returns to LO without GLITCH.
    pad[0] = 1'b0;
    wait_xres(0, 1'b0, 6, "stretch_pre_fall");
    pad[0] = 1'b1;
    repeat (8) tick();
    pad[0] = 1'b0;
    gl_pulses = 0;
    repeat (16) begin tick(); gl_pulses += int'(glitch[0]); end
    chk("stretch_no_glitch", gl_pulses, 32'd0);
    chk("stretch_held_low", {31'd0, xres[0]}, 32'd0);
    pad[0] = 1'b1;
    wait_xres(0, 1'b1, 14, "stretch_rerise");

    // Clear coinciding with a glitch pulse.
    pad[0] = 1'b0; repeat (3) tick(); pad[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (glitch[0] !== 1'b1 && n < 20);
    chk("glitch_seen", {31'd0, glitch[0]}, 32'd1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clear_wins", {16'd0, gcnt}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(11) == 0) pad[c] = ~pad[c];
        if ($urandom_range(11) == 0) filt_in[c] = ~filt_in[c];
        if ($urandom_range(59) == 0) sel[c] = ~sel[c];
      end
      if ($urandom_range(79) == 0) en_h = ~en_h;
      if ($urandom_range(79) == 0) en_sig = ~en_sig;
      if ($urandom_range(39) == 0) en_vddio = ~en_vddio;
      cnt_clr = ($urandom_range(99) == 0);
      reset   = ($urandom_range(499) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
